ocx_dlx_rx_gbx: RTL and testbench
=================================

Name: ocx_dlx_rx_gbx

Overview:
Receive-side gearbox companion to the DLX TX gearbox. It takes 64-bit data plus a 2-bit sync header from the PHY RX gearbox, achieves and holds 64b/66b block lock by pulsing a bitslip request, and classifies each header as data or control. When EDPL is enabled it checks the parity-encoded data headers (01 = even, alternating 00/11 = odd). It sits between the PHY RX interface and the DLX RX framer/training control.

Parameters:
LOCK_CNT, 64, consecutive valid headers required in HUNT to declare lock
WIN_CNT, 64, header window length in LOCKED
BAD_MAX, 16, invalid headers within one window that force loss of lock
SLIP_WAIT, 32, cycles after a slip before HUNT resumes counting
EDPL_CNT_W, 8, width of the EDPL error counter

Ports:
dlx_clk  in  1  clock
dlx_reset_n  in  1  reset, asynchronous, active-low
phy_dlx_rx_valid  in  1  header/data valid from the PHY gearbox; deasserts one cycle in 33
phy_dlx_rx_header  in  2  received sync header
phy_dlx_rx_data  in  64  received block payload
dlx_phy_rx_slip  out  1  one-cycle bitslip request
edpl_ena  in  1  EDPL parity-header mode enable
edpl_thresh  in  EDPL_CNT_W  error count at which edpl_max_hit asserts
edpl_cnt_clr  in  1  synchronous clear of the EDPL counter and sticky
gb_rx_valid  out  1  output block valid
gb_rx_data  out  64  output payload
gb_rx_ctl  out  1  block carried control header 10
gb_rx_block_lock  out  1  block lock achieved
gb_rx_edpl_err  out  1  one-cycle pulse per EDPL error
gb_rx_edpl_cnt  out  EDPL_CNT_W  saturating EDPL error count
gb_rx_edpl_max_hit  out  1  sticky flag: counter >= edpl_thresh (thresh != 0)

Behaviour:
- Reset (async assert, synchronous deassert handled upstream): every output is 0, FSM is in HUNT, all counters are 0, exp_odd_hdr = 0.
- Header classification:
  - 10 = control, 01 = data.
  - 00 and 11 are invalid, except in LOCKED with edpl_ena = 1, where they are valid odd-parity data headers.
- Only cycles with phy_dlx_rx_valid = 1 advance any counter or check. Invalid-input cycles hold all state.
- FSM states: HUNT, SLIP, WAIT, LOCKED.
  - HUNT: a valid header increments good_cnt. good_cnt reaching LOCK_CNT goes to LOCKED. An invalid header goes to SLIP and sets good_cnt = 0.
  - SLIP: dlx_phy_rx_slip = 1 for exactly one cycle, then go to WAIT.
  - WAIT: count SLIP_WAIT dlx_clk cycles, ignoring valid and headers, then go to HUNT.
  - LOCKED: gb_rx_block_lock = 1. win_cnt counts valid cycles; bad_cnt counts invalid headers.
    - bad_cnt reaching BAD_MAX goes to SLIP and drops lock that same cycle.
    - win_cnt wrapping at WIN_CNT clears both counters. If the window end and the BAD_MAX-th bad header coincide, the slip wins.
- Data path: a 2-stage register pipeline, so gb_rx_* appears 2 cycles after the PHY inputs.
  - gb_rx_valid = input valid AND the FSM was LOCKED at stage 1.
  - gb_rx_ctl = header was 10.
  - gb_rx_data passes through unmodified; it is held when valid = 0.
- EDPL check (LOCKED, edpl_ena = 1, valid input, non-control header). Stage 1 computes odd = XOR of the 64 data bits. An error is flagged when any of these holds:
  - header 01 and odd = 1;
  - header 00/11 and odd = 0;
  - header 00/11 and header != {exp_odd_hdr, exp_odd_hdr}.
- exp_odd_hdr update:
  - On every 00/11 header it becomes the inverse of the received header bit (resynchronises after an error).
  - It is cleared when edpl_ena = 0 or when lock drops.
- gb_rx_edpl_err pulses aligned with the block's gb_rx_valid.
- The counter increments once per error and saturates at all-ones. edpl_cnt_clr has priority over a simultaneous increment.
- gb_rx_edpl_max_hit sets when the count is >= edpl_thresh with thresh != 0. It clears only on edpl_cnt_clr or reset.
- Reset asserted mid-lock: immediate return to HUNT; outputs zero asynchronously.
- edpl_ena toggling mid-window: takes effect on the next valid cycle. A 00/11 header in that cycle is classified by the new value.

Decomposition:
- ocx_dlx_pkg holds:
  - header encodings (HDR_DATA = 2'b01, HDR_CTL = 2'b10, HDR_ODD0 = 2'b00, HDR_ODD1 = 2'b11);
  - the FSM state enum;
  - the default LOCK_CNT/WIN_CNT/BAD_MAX/SLIP_WAIT constants.
- One sub-module, ocx_dlx_rx_blklock: the block-lock FSM, its counters and the slip output. The top level holds the data pipeline and the EDPL checker.

Test Plan:
- Clean lock: 64 valid cycles of header 01 -> gb_rx_block_lock rises after the 64th valid header, no slip; gb_rx_valid follows at 2-cycle latency.
- Misaligned start: header 11 at cycle 5 with edpl_ena = 0 -> slip pulse 1 cycle; no counting for 32 cycles; then 64 good headers -> lock.
- Loss of lock: in LOCKED, 16 headers of 00 within a 64-window (edpl_ena = 0) -> lock drops and slip pulses on the 16th; 15 bad headers then window end -> lock held.
- EDPL good stream: edpl_ena = 1; data 0x1 with headers 00, 11, 00, and data 0x3 with 01 -> no error, counter 0.
- EDPL errors: data 0x1 with header 01 -> err pulse, count 1. Repeated 00, 00 on odd data -> err on the second. With edpl_thresh = 2, max_hit sets; edpl_cnt_clr -> count 0, max_hit 0.
- Async reset mid-LOCKED with valid gaps every 33rd cycle -> all outputs 0 immediately; relock takes 64 valid headers, not cycles.

Source files
------------

// File: rtl/ocx_dlx_pkg.sv
// Shared constants and types for the DLX receive gearbox: sync-header encodings,
// block-lock FSM states and the default lock/window/slip timing.
package ocx_dlx_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTL  = 2'b10;
  localparam logic [1:0] HDR_ODD0 = 2'b00;
  localparam logic [1:0] HDR_ODD1 = 2'b11;

  localparam int LOCK_CNT_DFLT   = 64;
  localparam int WIN_CNT_DFLT    = 64;
  localparam int BAD_MAX_DFLT    = 16;
  localparam int SLIP_WAIT_DFLT  = 32;
  localparam int EDPL_CNT_W_DFLT = 8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } blk_state_e;

endpackage

// File: rtl/ocx_dlx_rx_blklock.sv
// 64b/66b block-lock state machine: hunts for LOCK_CNT consecutive good headers,
// requests a bitslip on a bad one, and drops lock after BAD_MAX bad headers per window.
module ocx_dlx_rx_blklock
  import ocx_dlx_pkg::*;
#(
  parameter int LOCK_CNT  = LOCK_CNT_DFLT,
  parameter int WIN_CNT   = WIN_CNT_DFLT,
  parameter int BAD_MAX   = BAD_MAX_DFLT,
  parameter int SLIP_WAIT = SLIP_WAIT_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [1:0] rx_header,
  input  logic       edpl_ena,
  output logic       slip,
  output logic       block_lock
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_CNT + 1);
  localparam int BW = $clog2(BAD_MAX + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  blk_state_e    state, state_nxt;
  logic [GW-1:0] good_cnt;
  logic [WW-1:0] win_cnt;
  logic [BW-1:0] bad_cnt;
  logic [SW-1:0] wait_cnt;
  logic          hdr_bad;
  logic          good_hit;
  logic          bad_hit;
  logic          win_end;
  logic          wait_end;

  // 00/11 are only legal once locked with EDPL parity headers enabled
  always_comb begin
    hdr_bad  = ((rx_header == HDR_ODD0) || (rx_header == HDR_ODD1)) &&
               !((state == ST_LOCKED) && edpl_ena);
    good_hit = (good_cnt == GW'(LOCK_CNT - 1));
    bad_hit  = hdr_bad && (bad_cnt == BW'(BAD_MAX - 1));
    win_end  = (win_cnt == WW'(WIN_CNT - 1));
    wait_end = (wait_cnt == SW'(SLIP_WAIT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT: begin
        if (rx_valid) begin
          if (hdr_bad)       state_nxt = ST_SLIP;
          else if (good_hit) state_nxt = ST_LOCKED;
        end
      end
      ST_SLIP:   state_nxt = ST_WAIT;
      ST_WAIT:   if (wait_end) state_nxt = ST_HUNT;
      ST_LOCKED: if (rx_valid && bad_hit) state_nxt = ST_SLIP;
      default:   state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    slip       = (state == ST_SLIP);
    block_lock = (state == ST_LOCKED);
  end

  // A slip on the BAD_MAX-th bad header takes priority over the window wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      win_cnt  <= '0;
      bad_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (rx_valid) good_cnt <= (hdr_bad || good_hit) ? '0 : good_cnt + GW'(1);
        end
        ST_WAIT: wait_cnt <= wait_end ? '0 : wait_cnt + SW'(1);
        ST_LOCKED: begin
          if (rx_valid) begin
            if (bad_hit || win_end) begin
              win_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              bad_cnt <= bad_cnt + BW'(hdr_bad);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ocx_dlx_rx_gbx.sv
// DLX receive gearbox: block lock via ocx_dlx_rx_blklock, a 2-stage data pipeline,
// and the EDPL parity-header checker with its saturating error counter.
module ocx_dlx_rx_gbx
  import ocx_dlx_pkg::*;
#(
  parameter int LOCK_CNT   = LOCK_CNT_DFLT,
  parameter int WIN_CNT    = WIN_CNT_DFLT,
  parameter int BAD_MAX    = BAD_MAX_DFLT,
  parameter int SLIP_WAIT  = SLIP_WAIT_DFLT,
  parameter int EDPL_CNT_W = EDPL_CNT_W_DFLT
) (
  input  logic                  dlx_clk,
  input  logic                  dlx_reset_n,
  input  logic                  phy_dlx_rx_valid,
  input  logic [1:0]            phy_dlx_rx_header,
  input  logic [63:0]           phy_dlx_rx_data,
  output logic                  dlx_phy_rx_slip,
  input  logic                  edpl_ena,
  input  logic [EDPL_CNT_W-1:0] edpl_thresh,
  input  logic                  edpl_cnt_clr,
  output logic                  gb_rx_valid,
  output logic [63:0]           gb_rx_data,
  output logic                  gb_rx_ctl,
  output logic                  gb_rx_block_lock,
  output logic                  gb_rx_edpl_err,
  output logic [EDPL_CNT_W-1:0] gb_rx_edpl_cnt,
  output logic                  gb_rx_edpl_max_hit
);

  logic        block_lock;
  logic        exp_odd_hdr;
  logic        in_hdr_odd;
  logic        s1_ld;
  logic        s1_valid;
  logic        s1_ctl;
  logic        s1_chk;
  logic        s1_odd;
  logic        s1_exp;
  logic [1:0]  s1_hdr;
  logic [63:0] s1_data;
  logic        s1_hdr_odd;
  logic        edpl_err_nxt;

  ocx_dlx_rx_blklock #(
    .LOCK_CNT  (LOCK_CNT),
    .WIN_CNT   (WIN_CNT),
    .BAD_MAX   (BAD_MAX),
    .SLIP_WAIT (SLIP_WAIT)
  ) u_blklock (
    .clk        (dlx_clk),
    .rst_n      (dlx_reset_n),
    .rx_valid   (phy_dlx_rx_valid),
    .rx_header  (phy_dlx_rx_header),
    .edpl_ena   (edpl_ena),
    .slip       (dlx_phy_rx_slip),
    .block_lock (block_lock)
  );

  assign gb_rx_block_lock = block_lock;
  assign in_hdr_odd = (phy_dlx_rx_header == HDR_ODD0) || (phy_dlx_rx_header == HDR_ODD1);

  // Odd headers alternate; following the received one resynchronises after an error
  always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
    if (!dlx_reset_n)                  exp_odd_hdr <= 1'b0;
    else if (!block_lock || !edpl_ena) exp_odd_hdr <= 1'b0;
    else if (phy_dlx_rx_valid && in_hdr_odd) exp_odd_hdr <= ~phy_dlx_rx_header[0];
  end

  always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
    if (!dlx_reset_n) begin
      s1_ld    <= 1'b0;
      s1_valid <= 1'b0;
      s1_ctl   <= 1'b0;
      s1_chk   <= 1'b0;
      s1_exp   <= 1'b0;
      s1_odd   <= 1'b0;
      s1_hdr   <= '0;
      s1_data  <= '0;
    end else begin
      s1_ld    <= phy_dlx_rx_valid;
      s1_valid <= phy_dlx_rx_valid && block_lock;
      s1_ctl   <= (phy_dlx_rx_header == HDR_CTL);
      s1_chk   <= phy_dlx_rx_valid && block_lock && edpl_ena && (phy_dlx_rx_header != HDR_CTL);
      s1_exp   <= exp_odd_hdr;
      if (phy_dlx_rx_valid) begin
        s1_hdr  <= phy_dlx_rx_header;
        s1_data <= phy_dlx_rx_data;
        s1_odd  <= ^phy_dlx_rx_data;
      end
    end
  end

  always_comb begin
    s1_hdr_odd   = (s1_hdr == HDR_ODD0) || (s1_hdr == HDR_ODD1);
    edpl_err_nxt = s1_chk &&
                   (((s1_hdr == HDR_DATA) && s1_odd) ||
                    (s1_hdr_odd && (!s1_odd || (s1_hdr != {s1_exp, s1_exp}))));
  end

  always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
    if (!dlx_reset_n) begin
      gb_rx_valid    <= 1'b0;
      gb_rx_ctl      <= 1'b0;
      gb_rx_data     <= '0;
      gb_rx_edpl_err <= 1'b0;
    end else begin
      gb_rx_valid    <= s1_valid;
      gb_rx_ctl      <= s1_valid && s1_ctl;
      gb_rx_edpl_err <= edpl_err_nxt;
      if (s1_ld) gb_rx_data <= s1_data;
    end
  end

  // Clear beats a simultaneous increment; max_hit stays set until cleared
  always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
    if (!dlx_reset_n) begin
      gb_rx_edpl_cnt     <= '0;
      gb_rx_edpl_max_hit <= 1'b0;
    end else if (edpl_cnt_clr) begin
      gb_rx_edpl_cnt     <= '0;
      gb_rx_edpl_max_hit <= 1'b0;
    end else begin
      if (edpl_err_nxt && (gb_rx_edpl_cnt != '1))
        gb_rx_edpl_cnt <= gb_rx_edpl_cnt + EDPL_CNT_W'(1);
      if ((edpl_thresh != '0) && (gb_rx_edpl_cnt >= edpl_thresh))
        gb_rx_edpl_max_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ocx_dlx_rx_gbx.sv
// Randomized scoreboard bench for ocx_dlx_rx_gbx: a behavioural lock/EDPL model
// predicts each output block and a negedge monitor compares what the DUT presents.
module tb_ocx_dlx_rx_gbx;

  localparam int CW        = 8;
  localparam int LOCK_N    = 64;
  localparam int WIN_N     = 64;
  localparam int BAD_N     = 16;
  localparam int WAIT_N    = 32;
  localparam int CNT_MAX   = (1 << CW) - 1;

  logic          dlx_clk = 1'b0;
  logic          dlx_reset_n;
  logic          phy_dlx_rx_valid;
  logic [1:0]    phy_dlx_rx_header;
  logic [63:0]   phy_dlx_rx_data;
  logic          dlx_phy_rx_slip;
  logic          edpl_ena;
  logic [CW-1:0] edpl_thresh;
  logic          edpl_cnt_clr;
  logic          gb_rx_valid;
  logic [63:0]   gb_rx_data;
  logic          gb_rx_ctl;
  logic          gb_rx_block_lock;
  logic          gb_rx_edpl_err;
  logic [CW-1:0] gb_rx_edpl_cnt;
  logic          gb_rx_edpl_max_hit;

  ocx_dlx_rx_gbx dut (
    .dlx_clk            (dlx_clk),
    .dlx_reset_n        (dlx_reset_n),
    .phy_dlx_rx_valid   (phy_dlx_rx_valid),
    .phy_dlx_rx_header  (phy_dlx_rx_header),
    .phy_dlx_rx_data    (phy_dlx_rx_data),
    .dlx_phy_rx_slip    (dlx_phy_rx_slip),
    .edpl_ena           (edpl_ena),
    .edpl_thresh        (edpl_thresh),
    .edpl_cnt_clr       (edpl_cnt_clr),
    .gb_rx_valid        (gb_rx_valid),
    .gb_rx_data         (gb_rx_data),
    .gb_rx_ctl          (gb_rx_ctl),
    .gb_rx_block_lock   (gb_rx_block_lock),
    .gb_rx_edpl_err     (gb_rx_edpl_err),
    .gb_rx_edpl_cnt     (gb_rx_edpl_cnt),
    .gb_rx_edpl_max_hit (gb_rx_edpl_max_hit)
  );

  always #5 dlx_clk = ~dlx_clk;

  typedef struct packed {
    logic [63:0] data;
    logic        ctl;
    logic        err;
  } blk_t;

  blk_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: lock status, pending slip, remaining wait, per-phase tallies
  bit m_locked, m_slip, m_exp;
  int m_wait, m_good, m_win, m_bad;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic gapValid();
    return (cyc % 33) != 32;
  endfunction

  function automatic logic [1:0] goodHdr();
    return ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] oddHdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic modelReset();
    m_locked = 0; m_slip = 0; m_exp = 0;
    m_wait = 0; m_good = 0; m_win = 0; m_bad = 0;
    expq.delete();
  endtask

  task automatic checkOutput();
    checks++;
    if (gb_rx_block_lock !== m_locked || dlx_phy_rx_slip !== m_slip) begin
      failures++;
      $display("[TB] FAIL lock_slip cyc=%0d got lock=%b slip=%b expected lock=%b slip=%b",
               cyc, gb_rx_block_lock, dlx_phy_rx_slip, m_locked, m_slip);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] hdr, input logic [63:0] d,
                               input logic ena, input logic clr);
    blk_t b;
    logic odd, oddh;
    phy_dlx_rx_valid  = v;
    phy_dlx_rx_header = hdr;
    phy_dlx_rx_data   = d;
    edpl_ena          = ena;
    edpl_cnt_clr      = clr;
    odd  = ^d;
    oddh = (hdr == 2'b00) || (hdr == 2'b11);
    if (v && m_locked) begin
      b.data = d;
      b.ctl  = (hdr == 2'b10);
      b.err  = ena && (hdr != 2'b10) &&
               ((hdr == 2'b01 && odd) || (oddh && (!odd || hdr != {m_exp, m_exp})));
      expq.push_back(b);
    end
    if (!m_locked || !ena) m_exp = 0;
    else if (v && oddh)    m_exp = ~hdr[0];
    if (m_slip) begin
      m_slip = 0;
      m_wait = WAIT_N;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (m_locked) begin
      if (v) begin
        if (oddh && !ena) m_bad++;
        m_win++;
        if (m_bad == BAD_N) begin
          m_locked = 0; m_slip = 1; m_win = 0; m_bad = 0;
        end else if (m_win == WIN_N) begin
          m_win = 0; m_bad = 0;
        end
      end
    end else if (v) begin
      if (oddh) begin
        m_slip = 1; m_good = 0;
      end else begin
        m_good++;
        if (m_good == LOCK_N) begin
          m_locked = 1; m_good = 0; m_win = 0; m_bad = 0;
        end
      end
    end
    @(posedge dlx_clk);
    #1;
    checkOutput();
    cyc++;
  endtask

  // Assert reset between clock edges and confirm every output clears without a clock
  task automatic doReset();
    #2;
    dlx_reset_n = 1'b0;
    #1;
    checks++;
    if ({dlx_phy_rx_slip, gb_rx_valid, gb_rx_data, gb_rx_ctl, gb_rx_block_lock,
         gb_rx_edpl_err, gb_rx_edpl_cnt, gb_rx_edpl_max_hit} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got lock=%b valid=%b slip=%b cnt=%0d maxhit=%b data=%h expected all zero",
               gb_rx_block_lock, gb_rx_valid, dlx_phy_rx_slip, gb_rx_edpl_cnt,
               gb_rx_edpl_max_hit, gb_rx_data);
    end
    modelReset();
    @(posedge dlx_clk);
    @(posedge dlx_clk);
    #1;
    dlx_reset_n = 1'b1;
  endtask

  task automatic ensureLock(input logic ena);
    for (int i = 0; i < 300 && !m_locked; i++)
      applyStimulus(gapValid(), goodHdr(), rand64(), ena, 1'b0);
  endtask

  // Monitor: pops one expected block per DUT output and tracks the EDPL counter
  int   mon_cnt = 0;
  bit   mon_mh = 0;
  bit   last_clr = 0;
  int   last_thr = 0;
  always @(negedge dlx_clk) begin
    blk_t b;
    bit   eerr;
    bit   nmh;
    if (!dlx_reset_n) begin
      mon_cnt = 0; mon_mh = 0; last_clr = 0; last_thr = 0;
    end else begin
      eerr = 0;
      checks++;
      if (gb_rx_valid) begin
        if (expq.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_block got data=%h with no block expected", gb_rx_data);
        end else begin
          b = expq.pop_front();
          eerr = b.err;
          if (gb_rx_data !== b.data || gb_rx_ctl !== b.ctl || gb_rx_edpl_err !== b.err) begin
            failures++;
            $display("[TB] FAIL block got data=%h ctl=%b err=%b expected data=%h ctl=%b err=%b",
                     gb_rx_data, gb_rx_ctl, gb_rx_edpl_err, b.data, b.ctl, b.err);
          end
        end
      end else if (gb_rx_edpl_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL err_without_valid got err=%b expected 0", gb_rx_edpl_err);
      end
      nmh     = last_clr ? 1'b0 : (mon_mh || (last_thr != 0 && mon_cnt >= last_thr));
      mon_cnt = last_clr ? 0 : ((eerr && mon_cnt != CNT_MAX) ? mon_cnt + 1 : mon_cnt);
      mon_mh  = nmh;
      checks++;
      if (int'(gb_rx_edpl_cnt) != mon_cnt || gb_rx_edpl_max_hit !== mon_mh) begin
        failures++;
        $display("[TB] FAIL edpl_count got cnt=%0d maxhit=%b expected cnt=%0d maxhit=%b",
                 gb_rx_edpl_cnt, gb_rx_edpl_max_hit, mon_cnt, mon_mh);
      end
      last_clr = edpl_cnt_clr;
      last_thr = int'(edpl_thresh);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ena;
    logic [63:0] d;
    logic [1:0]  h;
    dlx_reset_n       = 1'b0;
    phy_dlx_rx_valid  = 1'b0;
    phy_dlx_rx_header = 2'b00;
    phy_dlx_rx_data   = '0;
    edpl_ena          = 1'b0;
    edpl_thresh       = 8'd2;
    edpl_cnt_clr      = 1'b0;
    doReset();

    // Misaligned start: one bad header, slip, wait, then a clean lock
    for (int i = 0; i < 140; i++)
      applyStimulus(gapValid(), (i == 5) ? 2'b11 : goodHdr(), rand64(), 1'b0, 1'b0);

    // Locked with a bad-header rate that sometimes crosses BAD_MAX per window
    for (int i = 0; i < 700; i++)
      applyStimulus(gapValid(),
                    (m_locked && $urandom_range(0, 99) < 22) ? oddHdr() : goodHdr(),
                    rand64(), 1'b0, 1'b0);

    // Directed EDPL sequence
    ensureLock(1'b1);
    applyStimulus(1'b1, 2'b00, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b11, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b00, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 64'h3, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b00, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b00, 64'h1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 64'h3, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 64'h3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 64'h3, 1'b1, 1'b0);

    // Random EDPL traffic with enable toggles and occasional clears
    ena = 1'b1;
    edpl_thresh = 8'd3;
    for (int i = 0; i < 600; i++) begin
      d = rand64();
      if ($urandom_range(0, 99) < 5) ena = ~ena;
      if (!m_locked)                       h = goodHdr();
      else if ($urandom_range(0, 99) < 15) h = 2'b10;
      else if ($urandom_range(0, 99) < 88) h = (^d) ? {m_exp, m_exp} : 2'b01;
      else                                 h = ($urandom_range(0, 2) == 0) ? 2'b01 : oddHdr();
      applyStimulus(gapValid(), h, d, ena, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end

    // Every block an error: counter must saturate at all-ones
    edpl_thresh = 8'd200;
    ensureLock(1'b1);
    for (int i = 0; i < 340; i++) begin
      d = rand64();
      if (!(^d)) d[0] = ~d[0];
      applyStimulus(gapValid(), 2'b01, d, 1'b1, 1'b0);
    end

    // Async reset mid-lock, then relock across valid gaps
    ensureLock(1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(gapValid(), goodHdr(), rand64(), 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 140; i++) applyStimulus(gapValid(), goodHdr(), rand64(), 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b01, '0, 1'b0, 1'b0);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got %0d blocks outstanding expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
